// File: rtl/gfp8_nv_dot_sequencer.sv
// ============================================================================
// Module   : gfp8_nv_dot_sequencer
// Purpose  : Drives one GFP8 native-vector dot engine over a K-loop of NVs.
//            It issues the NV buffer reads, produces the dot-engine latch
//            pulses, and accumulates the returned GFP partials into a single
//            GFP result. The result is delivered over a valid/ready handshake.
// Options  : GFP8_SEQ_SAT_EN - saturating accumulator add plus a sticky
//            o_sat_flag output. When it is undefined, the add wraps.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module gfp8_nv_dot_sequencer #(
  parameter int ADDR_W      = 9,
  parameter int CNT_W       = 8,
  parameter int RD_LATENCY  = 1,
  parameter int DOT_LATENCY = 5
) (
  input  logic                     i_clk,
  input  logic                     i_reset_n,
  input  logic                     i_cmd_valid,
  output logic                     o_cmd_ready,
  input  logic [ADDR_W-1:0]        i_cmd_base_addr,
  input  logic [CNT_W-1:0]         i_cmd_num_nv,
  input  logic                     i_abort,
  output logic                     o_nv_rd_en,
  output logic [ADDR_W-1:0]        o_nv_rd_addr,
  output logic                     o_dot_input_valid,
  input  logic signed [31:0]       i_dot_mantissa,
  input  logic signed [7:0]        i_dot_exponent,
  output logic                     o_result_valid,
  input  logic                     i_result_ready,
  output logic signed [31:0]       o_result_mantissa,
  output logic signed [7:0]        o_result_exponent,
  output logic                     o_busy
`ifdef GFP8_SEQ_SAT_EN
  ,
  output logic                     o_sat_flag
`endif
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ISSUE  = 2'd1,
    S_DRAIN  = 2'd2,
    S_OUTPUT = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [ADDR_W-1:0]     r_base;
  logic [CNT_W-1:0]      r_num;
  logic [CNT_W-1:0]      r_issue_cnt;
  logic [CNT_W-1:0]      r_ret_cnt;
  logic [CNT_W-1:0]      w_ret_cnt_next;
  logic signed [31:0]    r_acc_m;
  logic signed [7:0]     r_acc_e;
  logic                  r_first;
  logic [DOT_LATENCY-1:0] r_dot_pipe;

  logic                  w_abort;
  logic                  w_cmd_accept;
  logic                  w_rd_en;
  logic                  w_dot_valid;
  logic                  w_ret_valid;

  // Abort only matters once a command is in flight
  assign w_abort      = i_abort && (r_state != S_IDLE);
  assign w_cmd_accept = (r_state == S_IDLE) && i_cmd_valid;
  // Abort gates the read strobe in the same cycle it is raised
  assign w_rd_en      = (r_state == S_ISSUE) && !i_abort;

  assign o_cmd_ready       = (r_state == S_IDLE);
  assign o_busy            = (r_state != S_IDLE);
  assign o_nv_rd_en        = w_rd_en;
  assign o_nv_rd_addr      = (r_state == S_ISSUE) ? (r_base + ADDR_W'(r_issue_cnt)) : '0;
  assign o_dot_input_valid = w_dot_valid;
  assign o_result_valid    = (r_state == S_OUTPUT);
  assign o_result_mantissa = (r_state == S_OUTPUT) ? r_acc_m : '0;
  assign o_result_exponent = (r_state == S_OUTPUT) ? r_acc_e : '0;

  // The read-data delay aligns the latch pulse with the buffer output
  generate
    if (RD_LATENCY == 0) begin : g_rd_pass
      assign w_dot_valid = w_rd_en;
    end else begin : g_rd_pipe
      logic [RD_LATENCY-1:0] r_rd_pipe;
      // Read-strobe delay line; an abort drops every read still in flight
      always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n)   r_rd_pipe <= '0;
        else if (w_abort) r_rd_pipe <= '0;
        else              r_rd_pipe <= (r_rd_pipe << 1) | RD_LATENCY'(w_rd_en);
      end
      assign w_dot_valid = r_rd_pipe[RD_LATENCY-1];
    end
  endgenerate

  // Dot-engine latency model; the engine has no output valid of its own
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n)   r_dot_pipe <= '0;
    else if (w_abort) r_dot_pipe <= '0;
    else              r_dot_pipe <= (r_dot_pipe << 1) | DOT_LATENCY'(w_dot_valid);
  end

  assign w_ret_valid    = r_dot_pipe[DOT_LATENCY-1] && !w_abort &&
                          ((r_state == S_ISSUE) || (r_state == S_DRAIN));
  assign w_ret_cnt_next = r_ret_cnt + (w_ret_valid ? CNT_W'(1) : CNT_W'(0));

  // Align both operands to the larger exponent (signed compare)
  logic signed [7:0]  w_max_e;
  logic [8:0]         w_sh_acc;
  logic [8:0]         w_sh_in;
  logic signed [31:0] w_acc_shifted;
  logic signed [31:0] w_in_shifted;
  logic [31:0]        w_add_res;
  logic               w_overflow;

  assign w_max_e       = (r_acc_e > i_dot_exponent) ? r_acc_e : i_dot_exponent;
  assign w_sh_acc      = {w_max_e[7], w_max_e} - {r_acc_e[7], r_acc_e};
  assign w_sh_in       = {w_max_e[7], w_max_e} - {i_dot_exponent[7], i_dot_exponent};
  // Shifts past the mantissa width flush to zero, including for negative values
  assign w_acc_shifted = (w_sh_acc > 9'd31) ? 32'sd0 : (r_acc_m >>> w_sh_acc[4:0]);
  assign w_in_shifted  = (w_sh_in > 9'd31) ? 32'sd0 : (i_dot_mantissa >>> w_sh_in[4:0]);

`ifdef GFP8_SEQ_SAT_EN
  logic [32:0] w_sum_ext;
  logic        r_sat;
  assign w_sum_ext  = {w_acc_shifted[31], w_acc_shifted} + {w_in_shifted[31], w_in_shifted};
  assign w_overflow = w_sum_ext[32] ^ w_sum_ext[31];
  assign w_add_res  = !w_overflow ? w_sum_ext[31:0] :
                      (w_sum_ext[32] ? 32'h8000_0000 : 32'h7FFF_FFFF);
  assign o_sat_flag = r_sat;

  // Sticky saturation flag, cleared when a new command is accepted
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n)                             r_sat <= 1'b0;
    else if (w_cmd_accept)                      r_sat <= 1'b0;
    else if (w_ret_valid && !r_first && w_overflow) r_sat <= 1'b1;
  end
`else
  assign w_overflow = 1'b0;
  assign w_add_res  = w_acc_shifted + w_in_shifted;
`endif

  // Command latch, issue/return counters and the GFP accumulator
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_base      <= '0;
      r_num       <= '0;
      r_issue_cnt <= '0;
      r_ret_cnt   <= '0;
      r_acc_m     <= '0;
      r_acc_e     <= '0;
      r_first     <= 1'b0;
    end else if (w_cmd_accept) begin
      r_base      <= i_cmd_base_addr;
      r_num       <= i_cmd_num_nv;
      r_issue_cnt <= '0;
      r_ret_cnt   <= '0;
      r_acc_m     <= '0;
      r_acc_e     <= '0;
      r_first     <= 1'b1;
    end else begin
      if (w_rd_en) r_issue_cnt <= r_issue_cnt + CNT_W'(1);
      if (w_ret_valid) begin
        r_ret_cnt <= w_ret_cnt_next;
        r_first   <= 1'b0;
        r_acc_m   <= r_first ? i_dot_mantissa : w_add_res;
        r_acc_e   <= r_first ? i_dot_exponent : w_max_e;
      end
    end
  end

  // State register
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) r_state <= S_IDLE;
    else            r_state <= w_state_next;
  end

  // Next-state logic; abort always wins outside IDLE
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_cmd_valid) w_state_next = (i_cmd_num_nv == '0) ? S_OUTPUT : S_ISSUE;
      end
      S_ISSUE: begin
        if (i_abort)                                 w_state_next = S_IDLE;
        else if (r_issue_cnt == r_num - CNT_W'(1))   w_state_next = S_DRAIN;
      end
      S_DRAIN: begin
        if (i_abort)                       w_state_next = S_IDLE;
        else if (w_ret_cnt_next == r_num)  w_state_next = S_OUTPUT;
      end
      S_OUTPUT: begin
        if (i_result_ready || i_abort) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

endmodule

`default_nettype wire
